// File: rtl/dual_sram_ctrl.sv
// rtl/dual_sram_ctrl.sv - byte-wide req/ack controller for two shared-address async SRAMs (chip 1 enabled by DUAL_SRAM_EN)
module dual_sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [19:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [18:0] SRAM_A,
    inout  wire  [7:0]  SRAM_D,
    output logic        SRAM_WE_n,
    output logic [18:0] SRAM2_A,
    inout  wire  [7:0]  SRAM2_D,
    output logic        SRAM2_WE_n
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

    state_t      state, state_n;
    logic        we_q, cs_q;
    logic [7:0]  wdata_q;
    logic [18:0] a_q;
    logic [3:0]  cnt;
    logic        oe0, we0_n;
    logic        accept, addr_cs, cs_next, wr_next, drive_next, pulse_next;
    logic [7:0]  rd_bus;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req) state_n = SETUP;
            SETUP:   state_n = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_n = we_q ? HOLD : DONE;
            HOLD:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pad controls are computed from the next state so every pad is a flop output.
    assign accept     = (state == IDLE) && req;
    assign cs_next    = accept ? addr_cs : cs_q;
    assign wr_next    = accept ? we : we_q;
    assign drive_next = wr_next && (state_n == SETUP || state_n == ACCESS || state_n == HOLD);
    assign pulse_next = wr_next && (state_n == ACCESS);

    assign ack       = (state == DONE);
    assign busy      = (state != IDLE);
    assign SRAM_A    = a_q;
    assign SRAM_WE_n = we0_n;
    assign SRAM_D    = oe0 ? wdata_q : 8'hzz;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            cs_q    <= 1'b0;
            wdata_q <= 8'h00;
            a_q     <= 19'd0;
            cnt     <= 4'd0;
            oe0     <= 1'b0;
            we0_n   <= 1'b1;
            rdata   <= 8'h00;
        end else begin
            state <= state_n;
            if (accept) begin
                we_q    <= we;
                cs_q    <= addr_cs;
                wdata_q <= wdata;
                a_q     <= addr[18:0];
            end
            if (state == SETUP)
                cnt <= 4'(WAIT_CYCLES - 1);
            else if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            oe0   <= drive_next && !cs_next;
            we0_n <= !(pulse_next && !cs_next);
            if (state == ACCESS && cnt == 4'd0 && !we_q)
                rdata <= rd_bus;
        end
    end

`ifdef DUAL_SRAM_EN
    logic oe1, we1_n;

    assign addr_cs    = addr[19];
    assign rd_bus     = cs_q ? SRAM2_D : SRAM_D;
    assign SRAM2_A    = a_q;
    assign SRAM2_WE_n = we1_n;
    assign SRAM2_D    = oe1 ? wdata_q : 8'hzz;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            oe1   <= 1'b0;
            we1_n <= 1'b1;
        end else begin
            oe1   <= drive_next && cs_next;
            we1_n <= !(pulse_next && cs_next);
        end
    end
`else
    // Single-chip board: chip 1 pads are parked and addr[19] has no effect.
    logic unused_ok;

    assign addr_cs    = 1'b0;
    assign rd_bus     = SRAM_D;
    assign SRAM2_A    = 19'd0;
    assign SRAM2_WE_n = 1'b1;
    assign SRAM2_D    = 8'hzz;
    assign unused_ok  = ^{SRAM2_D, addr[19]};
`endif

endmodule

// File: tb/tb_dual_sram_ctrl.sv
// tb/tb_dual_sram_ctrl.sv - self-checking bench for dual_sram_ctrl (WAIT_CYCLES 2 and 1)
module tb_dual_sram_ctrl;

    localparam int W = 2;
`ifdef DUAL_SRAM_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0, we = 1'b0, mdrv = 1'b0;
    logic [19:0] addr = '0;
    logic [7:0]  wdata = '0;

    logic        ack_a, busy_a, wen0_a, wen1_a, ack_b, busy_b, wen0_b, wen1_b;
    logic [7:0]  rdata_a, rdata_b;
    logic [18:0] a0_a, a1_a, a0_b, a1_b;
    wire  [7:0]  d0_a, d1_a, d0_b, d1_b;

    int passed = 0, total = 0;

    always #5 clk = ~clk;

    dual_sram_ctrl #(.WAIT_CYCLES(W)) dut_a (
        .clk_100(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_a), .rdata(rdata_a), .busy(busy_a),
        .SRAM_A(a0_a), .SRAM_D(d0_a), .SRAM_WE_n(wen0_a),
        .SRAM2_A(a1_a), .SRAM2_D(d1_a), .SRAM2_WE_n(wen1_a));

    dual_sram_ctrl #(.WAIT_CYCLES(1)) dut_b (
        .clk_100(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_b), .rdata(rdata_b), .busy(busy_b),
        .SRAM_A(a0_b), .SRAM_D(d0_b), .SRAM_WE_n(wen0_b),
        .SRAM2_A(a1_b), .SRAM2_D(d1_b), .SRAM2_WE_n(wen1_b));

    // SRAM models: contents start as a pattern of the address; a write lands only
    // after a full-width WE_n pulse (minimum write pulse width of the part).
    logic [7:0]  mem0 [0:524287];
    logic [7:0]  mem1 [0:524287];
    int          lo0 = 0, lo1 = 0, wen1_low_seen = 0;
    logic [7:0]  cap0, cap1;
    logic [18:0] capa0, capa1;

    assign d0_a = mdrv ? mem0[a0_a] : 8'hzz;
    assign d1_a = mdrv ? mem1[a1_a] : 8'hzz;
    assign d0_b = mdrv ? (a0_b[7:0] ^ 8'h5A) : 8'hzz;

    initial begin
        for (int i = 0; i < 524288; i++) begin
            mem0[i] = 8'(i) ^ 8'h5A;
            mem1[i] = 8'(i) ^ 8'hC3;
        end
        forever begin
            @(negedge clk);
            if (!wen0_a) begin lo0++; cap0 = d0_a; capa0 = a0_a; end
            else begin if (lo0 >= W) mem0[capa0] = cap0; lo0 = 0; end
            if (!wen1_a) begin lo1++; cap1 = d1_a; capa1 = a1_a; wen1_low_seen++; end
            else begin if (lo1 >= W) mem1[capa1] = cap1; lo1 = 0; end
        end
    end

    // Reference memory: flat byte map keyed by (chip, chip address).
    logic [7:0] sb [int];

    function automatic int key_of(input logic [19:0] a);
        return DUAL ? int'(a) : int'(a[18:0]);
    endfunction

    function automatic logic [7:0] sb_rd(input logic [19:0] a);
        int k;
        k = key_of(a);
        if (sb.exists(k)) return sb[k];
        return (k >= 524288) ? (8'(k) ^ 8'hC3) : (8'(k) ^ 8'h5A);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One access on instance a (inst=0) or b (inst=1); cycles counted from edge 0.
    task automatic run(input bit inst, input bit w, input logic [19:0] a, input logic [7:0] d,
                       output int ack_cyc, output int l0, output int l1, output logic [7:0] rd);
        @(negedge clk);
        we = w; addr = a; wdata = d; mdrv = !w;
        if (inst) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        ack_cyc = -1; l0 = 0; l1 = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!(inst ? wen0_b : wen0_a)) l0++;
            if (!(inst ? wen1_b : wen1_a)) l1++;
            if (inst ? ack_b : ack_a) begin ack_cyc = k; break; end
            @(negedge clk);
        end
        rd = inst ? rdata_b : rdata_a;
        @(negedge clk);
        check("ack_busy_drop", inst ? {ack_b, busy_b} : {ack_a, busy_a}, 2'b00);
        mdrv = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [19:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_rd;
        int          exp_ack;
        int          exp_lo0;
        int          exp_lo1;
    } vec_t;

    vec_t        tbl [11];
    logic [19:0] pool [8];
    int          ac, l0, l1;
    logic [7:0]  rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 20'h00123, 8'hA5, 8'h00, 3+W, W, 0};
        tbl[1]  = '{1'b0, 20'h00123, 8'h00, 8'hA5, 2+W, 0, 0};
        tbl[2]  = '{1'b1, 20'h80010, 8'h3C, 8'h00, 3+W, DUAL ? 0 : W, DUAL ? W : 0};
        tbl[3]  = '{1'b0, 20'h00010, 8'h00, DUAL ? 8'h4A : 8'h3C, 2+W, 0, 0};
        tbl[4]  = '{1'b0, 20'h80010, 8'h00, 8'h3C, 2+W, 0, 0};
        tbl[5]  = '{1'b1, 20'h7FFFF, 8'h11, 8'h00, 3+W, W, 0};
        tbl[6]  = '{1'b1, 20'h80000, 8'h22, 8'h00, 3+W, DUAL ? 0 : W, DUAL ? W : 0};
        tbl[7]  = '{1'b0, 20'h7FFFF, 8'h00, 8'h11, 2+W, 0, 0};
        tbl[8]  = '{1'b0, 20'h80000, 8'h00, 8'h22, 2+W, 0, 0};
        tbl[9]  = '{1'b0, 20'h00000, 8'h00, DUAL ? 8'h5A : 8'h22, 2+W, 0, 0};
        tbl[10] = '{1'b1, 20'h80005, 8'h77, 8'h00, 3+W, DUAL ? 0 : W, DUAL ? W : 0};
        pool = '{20'h00000, 20'h7FFFF, 20'h80000, 20'hFFFFF,
                 20'h00123, 20'h80123, 20'h00042, 20'h40042};

        repeat (3) @(negedge clk);
        check("rst_ack_busy", {ack_a, busy_a, ack_b, busy_b}, 4'b0000);
        check("rst_rdata", {rdata_a, rdata_b}, 16'h0000);
        check("rst_we_n", {wen0_a, wen1_a, wen0_b, wen1_b}, 4'b1111);
        check("rst_addr", {a0_a, a1_a}, 38'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, ac, l0, l1, rd);
            check($sformatf("tbl%0d_ack_cycle", i), ac, tbl[i].exp_ack);
            check($sformatf("tbl%0d_we0_low", i), l0, tbl[i].exp_lo0);
            check($sformatf("tbl%0d_we1_low", i), l1, tbl[i].exp_lo1);
            if (tbl[i].w) sb[key_of(tbl[i].a)] = tbl[i].d;
            else check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
        end
`ifdef DUAL_SRAM_EN
        check("chip1_mem_0x10", mem1[19'h00010], 8'h3C);
        check("chip1_mem_0x05", mem1[19'h00005], 8'h77);
`else
        check("chip0_mem_0x05", mem0[19'h00005], 8'h77);
        check("chip2_we_never_low", wen1_low_seen, 0);
        check("chip2_addr_zero", a1_a, 19'd0);
`endif

        // WAIT_CYCLES=1 instance
        run(1'b1, 1'b0, 20'h00045, 8'h00, ac, l0, l1, rd);
        check("w1_read_ack_cycle", ac, 3);
        check("w1_rdata", rd, 8'h45 ^ 8'h5A);
        run(1'b1, 1'b1, 20'h00046, 8'h12, ac, l0, l1, rd);
        check("w1_write_ack_cycle", ac, 4);
        check("w1_we_low", l0, 1);

        // req held high: writes back-to-back
        begin
            int last, n, bad_gap, dbl;
            logic prev;
            last = -1; n = 0; bad_gap = 0; dbl = 0; prev = 1'b0;
            @(negedge clk);
            we = 1'b1; addr = 20'h00300; wdata = 8'h99; mdrv = 1'b0; req_a = 1'b1;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (ack_a) begin
                    if (last >= 0 && c - last != 4 + W) bad_gap++;
                    if (prev) dbl++;
                    last = c; n++;
                end
                prev = ack_a;
            end
            req_a = 1'b0;
            for (int t = 0; t < 20 && busy_a; t++) @(negedge clk);
            check("cont_idle", busy_a, 1'b0);
            check("cont_ack_count", n, 8);
            check("cont_gap", bad_gap, 0);
            check("cont_double_ack", dbl, 0);
            sb[key_of(20'h00300)] = 8'h99;
        end

        // reset during the first ACCESS cycle of a write
        begin
            int acks;
            acks = 0;
            @(negedge clk);
            we = 1'b1; addr = 20'h00200; wdata = 8'hE7; req_a = 1'b1;
            @(posedge clk);
            @(negedge clk);
            req_a = 1'b0;
            @(negedge clk);
            check("abort_we_low_before", wen0_a, 1'b0);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort_we_n", wen0_a, 1'b1);
            check("abort_ack_busy", {ack_a, busy_a}, 2'b00);
            check("abort_rdata", rdata_a, 8'h00);
            for (int t = 0; t < 8; t++) begin
                @(negedge clk);
                if (ack_a) acks++;
            end
            check("abort_no_ack", acks, 0);
            run(1'b0, 1'b0, 20'h00200, 8'h00, ac, l0, l1, rd);
            check("abort_read_prewrite", rd, sb_rd(20'h00200));
        end

        // randomized accesses against the reference memory
        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [19:0] a;
            logic [7:0]  d;
            a = pool[$urandom_range(0, 7)];
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            run(1'b0, w, a, d, ac, l0, l1, rd);
            check($sformatf("rnd%0d_ack_cycle", i), ac, w ? 3 + W : 2 + W);
            check($sformatf("rnd%0d_we_low", i), l0 + l1, w ? W : 0);
            if (w) sb[key_of(a)] = d;
            else check($sformatf("rnd%0d_rdata_%05h", i, a), rd, sb_rd(a));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dual_sram_ctrl.md
# dual_sram_ctrl

Byte-wide request/acknowledge controller that turns system-side read and write requests into timed cycles on the board's two 512 KB asynchronous SRAMs, which share address lines. It sits between the chipset memory port and the SRAM pads, in the 100 MHz domain. Address bit 19 selects the chip. Read data is sampled from the selected chip's data bus; the chipset no longer drives the data pins unconditionally.

## Interface
Parameters:
- WAIT_CYCLES, 2: number of cycles WE_n is held low (writes) or data settles (reads); legal range 1..15.

Ports:
- clk_100  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; latched with req.
- addr  in  20  byte address; [19] chip select, [18:0] chip address.
- wdata  in  8  write data; latched with req.
- ack  out  1  one-cycle completion pulse.
- rdata  out  8  read data; valid from the ack cycle, held until the next read completes.
- busy  out  1  high whenever state ≠ IDLE.
- SRAM_A  out  19  chip 0 address.
- SRAM_D  inout  8  chip 0 data.
- SRAM_WE_n  out  1  chip 0 write enable.
- SRAM2_A  out  19  chip 1 address.
- SRAM2_D  inout  8  chip 1 data.
- SRAM2_WE_n  out  1  chip 1 write enable.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE.
- IDLE with req=1:
  - Latch we, addr and wdata into registers; go to SETUP.
  - req is ignored in every other state. There is no queueing.
- SETUP, 1 cycle:
  - Both SRAM_A and SRAM2_A carry the latched addr[18:0].
  - For a write, the selected chip's D bus is driven with the latched data and its WE_n stays 1.
  - Load the wait counter with WAIT_CYCLES-1 and go to ACCESS.
- ACCESS, WAIT_CYCLES cycles:
  - Write: the selected chip has WE_n=0 and its data is driven.
  - Read: both D buses are tri-stated and both WE_n are 1.
  - The counter decrements each cycle. At zero:
    - Read: rdata is loaded from the selected chip's D bus, and the FSM goes to DONE.
    - Write: the FSM goes to HOLD.
- HOLD, 1 cycle, writes only: WE_n=1 while data is still driven (data hold time). Go to DONE.
- DONE, 1 cycle: ack=1, D buses tri-stated, then back to IDLE.
- Unselected chip: WE_n=1 and D tri-stated at all times.
- A chip's D bus is never driven outside SETUP/ACCESS/HOLD of a write to that chip.
- All pad outputs (A, WE_n, D output enable, D output data) are registered; there is no combinational path from req/addr to the pads.
- Reset:
  - State IDLE, ack=0, busy=0, rdata=8'h00.
  - SRAM_A=SRAM2_A=0, both WE_n=1, both D tri-stated, counter 0.
  - A reset asserted mid-write aborts it: WE_n returns to 1 at the reset edge and no ack is issued.

## Timing
- Edge 0 is the edge at which req is sampled in IDLE.
- Read: ack is high during cycle 2+WAIT_CYCLES after edge 0 (cycle 4 at default). D is sampled at edge 1+WAIT_CYCLES.
- Write: ack is high during cycle 3+WAIT_CYCLES after edge 0 (cycle 5 at default). WE_n is low for exactly WAIT_CYCLES cycles, with 1 cycle of address/data setup before and 1 cycle of hold after.
- busy rises in the cycle after edge 0 and falls in the cycle after ack.
- The earliest next acceptance is the edge ending the first IDLE cycle after DONE.
- Throughput: one access per 3+WAIT_CYCLES cycles for reads, 4+WAIT_CYCLES for writes.
- Address boundaries:
  - addr=0x7FFFF selects chip 0 with A=0x7FFFF.
  - addr=0x80000 selects chip 1 with A=0x00000.
  - There is no wrap or carry between chips.

## Configuration
- DUAL_SRAM_EN defined: chip selection by addr[19] as described.
- DUAL_SRAM_EN undefined (single-chip boards):
  - addr[19] is ignored; every access goes to chip 0.
  - SRAM2_WE_n is tied to 1, SRAM2_D is permanently tri-stated, and SRAM2_A is 0.
  - Latencies are unchanged.

## Test plan
- Chip 0 write then read: write 8'hA5 to addr 0x00123, then read the same address (SRAM model present).
  - Write: SRAM_WE_n is low for exactly 2 cycles, SRAM2_WE_n stays 1, and ack falls in cycle 5.
  - Read: rdata=8'hA5 with ack in cycle 4.
- Chip 1 select: write 8'h3C to 0x80010, then read 0x00010 and 0x80010.
  - Chip 1 holds 3C at A=0x00010.
  - The read of 0x00010 returns chip 0 contents; the read of 0x80010 returns 8'h3C.
- req held high continuously: one access completes every 4+WAIT_CYCLES cycles for writes. No request is accepted while busy=1, and ack is never asserted for two consecutive cycles.
- Reset mid-write: reset asserted during the first ACCESS cycle.
  - Next cycle: WE_n=1, D tri-stated, state IDLE, no ack.
  - The following read returns the pre-write memory value.
- WAIT_CYCLES=1: read ack in cycle 3; write WE_n low for 1 cycle with ack in cycle 4.
- DUAL_SRAM_EN undefined: write 8'h77 to 0x80005. Chip 0 at A=0x00005 becomes 8'h77, and SRAM2_WE_n stays 1 throughout.
